hazard_ctrl: RTL

- Pipeline controller for the ID stage; sits beside the register file and control unit.
- Keeps a register scoreboard of in-flight writes and holds IF/ID on RAW or WAW hazards until the write-back stage commits.
- Sequences a fixed-length flush of IF/ID after a taken branch from EX.
- Decides each cycle whether the instruction in ID may issue into the ID/EX register.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : ID-stage hazard controller bus (decode, write-back, branch)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  id_valid_i;
  logic [ADDR_WIDTH-1:0] id_rs1_i;
  logic                  id_rs1_used_i;
  logic [ADDR_WIDTH-1:0] id_rs2_i;
  logic                  id_rs2_used_i;
  logic [ADDR_WIDTH-1:0] id_rd_i;
  logic                  id_rd_we_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_waddr_i;
  logic                  branch_taken_i;
  logic                  id_issue_o;
  logic                  stall_if_o;
  logic                  stall_id_o;
  logic                  flush_id_o;
  logic                  flush_ex_o;
  logic                  sb_busy_o;
  logic [NUM_REGS-1:0]   sb_pending_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
           id_rd_i, id_rd_we_i, wb_we_i, wb_waddr_i, branch_taken_i,
    input  id_issue_o, stall_if_o, stall_id_o, flush_id_o, flush_ex_o,
           sb_busy_o, sb_pending_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i,
           id_rd_i, id_rd_we_i, wb_we_i, wb_waddr_i, branch_taken_i,
    output id_issue_o, stall_if_o, stall_id_o, flush_id_o, flush_ex_o,
           sb_busy_o, sb_pending_o
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : ID-stage scoreboard, RAW/WAW stall and branch flush sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic hazard;
  logic in_flush;
  logic issue;

  // x0 never carries a dependency, so each term is masked by a nonzero check.
  always_comb begin
    hazard = bus.id_valid_i &
             ((bus.id_rs1_used_i & (bus.id_rs1_i != '0) & pend_q[bus.id_rs1_i]) |
              (bus.id_rs2_used_i & (bus.id_rs2_i != '0) & pend_q[bus.id_rs2_i]) |
              (bus.id_rd_we_i    & (bus.id_rd_i  != '0) & pend_q[bus.id_rd_i]));
  end

  assign in_flush = (state_q == FLUSH);
  assign issue    = bus.id_valid_i & ~hazard & ~bus.branch_taken_i & ~in_flush;

  assign bus.id_issue_o   = issue;
  assign bus.stall_if_o   = hazard & ~bus.branch_taken_i & ~in_flush;
  assign bus.stall_id_o   = hazard & ~bus.branch_taken_i & ~in_flush;
  assign bus.flush_id_o   = bus.branch_taken_i | in_flush;
  assign bus.flush_ex_o   = bus.branch_taken_i;
  assign bus.sb_busy_o    = |pend_q;
  assign bus.sb_pending_o = pend_q;

  // Set is applied after clear so a same-cycle issue to the same rd wins.
  always_comb begin
    pend_d = pend_q;
    if (bus.wb_we_i) begin
      pend_d[bus.wb_waddr_i] = 1'b0;
    end
    if (issue && bus.id_rd_we_i && (bus.id_rd_i != '0)) begin
      pend_d[bus.id_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.branch_taken_i) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (hazard) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (bus.branch_taken_i) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (!hazard) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        // EX holds a bubble here, so a branch indication cannot be genuine.
        if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule

`default_nettype wire
